// File: rtl/jtframe_stats_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : jtframe_stats_pkg                                          |
// | Brief   : Shared constants and helpers for the frame statistics unit |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package jtframe_stats_pkg;

    localparam int c_match_w = 4;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] w_max;
        w_max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= w_max) ? w_max : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_span_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : jtframe_span_cnt                                           |
// | Brief   : Edge-delimited saturating span counter with latch register |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module jtframe_span_cnt
    import jtframe_stats_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_cen,
    input  logic         i_edge_sig,
    input  logic         i_inc,
    output logic         o_rise,
    output logic         o_latch,
    output logic [W-1:0] o_lat,
    output logic [W-1:0] o_lat_nxt
);

    logic         r_prev;
    logic         r_valid;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_lat;
    logic         w_rise;
    logic         w_latch;

    assign w_rise  = i_cen & i_edge_sig & ~r_prev;
    assign w_latch = w_rise & r_valid;

    // The span opened before the first edge after reset is partial, so it is never latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_lat   <= '0;
        end else if (i_cen) begin
            r_prev <= i_edge_sig;
            if (w_rise) begin
                r_valid <= 1'b1;
                r_cnt   <= W'(i_inc);
                if (r_valid) begin
                    r_lat <= r_cnt;
                end
            end else if (i_inc) begin
                r_cnt <= W'(sat_inc(32'(r_cnt), W));
            end
        end
    end

    assign o_rise    = w_rise;
    assign o_latch   = w_latch;
    assign o_lat     = r_lat;
    assign o_lat_nxt = w_latch ? r_cnt : r_lat;

endmodule
`default_nettype wire

// File: rtl/jtframe_frame_stats.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : jtframe_frame_stats                                        |
// | Brief   : Video timing monitor: frame count, line/frame geometry,    |
// |           timing stability and frame-limit done flag                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module jtframe_frame_stats
    import jtframe_stats_pkg::*;
#(
    parameter int          CW            = 32,
    parameter int          LW            = 10,
    parameter int          PW            = 10,
    parameter int unsigned MAXFRAME      = 0,
    parameter int          STABLE_FRAMES = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          hs,
    input  logic          vs,
    input  logic          hb,
    input  logic          vb,
    output logic [CW-1:0] frame_cnt,
    output logic          frame_stb,
    output logic [PW-1:0] pxl_total,
    output logic [PW-1:0] pxl_vis,
    output logic [LW-1:0] lines_total,
    output logic [LW-1:0] lines_vis,
    output logic          stable,
    output logic          frames_done
);

    localparam logic [CW-1:0]        c_maxframe   = CW'(MAXFRAME);
    localparam bit                   c_done_en    = (MAXFRAME != 0);
    localparam logic [c_match_w-1:0] c_stable_thr = c_match_w'(STABLE_FRAMES);

    logic                 w_hs_rise;
    logic                 w_vs_rise;
    logic                 w_frame_latch;
    logic [PW-1:0]        w_pt_nxt;
    logic [LW-1:0]        w_lt_nxt;
    logic                 w_pt_latch;
    logic                 w_pv_rise;
    logic                 w_pv_latch;
    logic [PW-1:0]        w_pv_nxt;
    logic                 w_lv_rise;
    logic                 w_lv_latch;
    logic [LW-1:0]        w_lv_nxt;
    logic                 w_unused;

    logic [LW+PW-1:0]     w_sig_nxt;
    logic [LW+PW-1:0]     r_prev_sig;
    logic [c_match_w-1:0] r_match;
    logic [c_match_w-1:0] w_match_nxt;
    logic [CW-1:0]        w_frame_nxt;

    jtframe_span_cnt #(.W(PW)) u_pxl_total (
        .clk        (clk),
        .rst        (rst),
        .i_cen      (pxl_cen),
        .i_edge_sig (hs),
        .i_inc      (1'b1),
        .o_rise     (w_hs_rise),
        .o_latch    (w_pt_latch),
        .o_lat      (pxl_total),
        .o_lat_nxt  (w_pt_nxt)
    );

    jtframe_span_cnt #(.W(PW)) u_pxl_vis (
        .clk        (clk),
        .rst        (rst),
        .i_cen      (pxl_cen),
        .i_edge_sig (hs),
        .i_inc      (~hb),
        .o_rise     (w_pv_rise),
        .o_latch    (w_pv_latch),
        .o_lat      (pxl_vis),
        .o_lat_nxt  (w_pv_nxt)
    );

    // Line axis counts hs rises; a coincident hs rise lands in the new frame.
    jtframe_span_cnt #(.W(LW)) u_lines_total (
        .clk        (clk),
        .rst        (rst),
        .i_cen      (pxl_cen),
        .i_edge_sig (vs),
        .i_inc      (w_hs_rise),
        .o_rise     (w_vs_rise),
        .o_latch    (w_frame_latch),
        .o_lat      (lines_total),
        .o_lat_nxt  (w_lt_nxt)
    );

    jtframe_span_cnt #(.W(LW)) u_lines_vis (
        .clk        (clk),
        .rst        (rst),
        .i_cen      (pxl_cen),
        .i_edge_sig (vs),
        .i_inc      (w_hs_rise & ~vb),
        .o_rise     (w_lv_rise),
        .o_latch    (w_lv_latch),
        .o_lat      (lines_vis),
        .o_lat_nxt  (w_lv_nxt)
    );

    assign w_unused = ^{w_pt_latch, w_pv_rise, w_pv_latch, w_pv_nxt,
                        w_lv_rise, w_lv_latch, w_lv_nxt};

    // Frame signature uses the post-edge line length so a coincident hs rise is seen.
    assign w_sig_nxt   = {w_lt_nxt, w_pt_nxt};
    assign w_frame_nxt = frame_cnt + CW'(1);

    always_comb begin
        w_match_nxt = '0;
        if (w_sig_nxt == r_prev_sig) begin
            w_match_nxt = c_match_w'(sat_inc(32'(r_match), c_match_w));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            frame_stb   <= 1'b0;
            frames_done <= 1'b0;
            r_prev_sig  <= '0;
            r_match     <= '0;
            stable      <= 1'b0;
        end else begin
            frame_stb <= w_vs_rise;
            if (w_vs_rise) begin
                frame_cnt <= w_frame_nxt;
                if (c_done_en && (w_frame_nxt == c_maxframe)) begin
                    frames_done <= 1'b1;
                end
            end
            if (w_frame_latch) begin
                r_prev_sig <= w_sig_nxt;
                r_match    <= w_match_nxt;
                stable     <= (w_match_nxt >= c_stable_thr);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_frame_stats.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_jtframe_frame_stats                                     |
// | Brief   : Directed self-checking bench for jtframe_frame_stats       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_jtframe_frame_stats;

    localparam int CW = 32;
    localparam int LW = 10;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          pxl_cen;
    logic          hs, vs, hb, vb;

    logic [CW-1:0] frame_cnt;
    logic          frame_stb;
    logic [PW-1:0] pxl_total, pxl_vis;
    logic [LW-1:0] lines_total, lines_vis;
    logic          stable, frames_done;

    logic [CW-1:0] n_frame_cnt;
    logic          n_frame_stb;
    logic [PW-1:0] n_pxl_total, n_pxl_vis;
    logic [LW-1:0] n_lines_total, n_lines_vis;
    logic          n_stable, n_frames_done;

    int n_tests = 0;
    int n_fail  = 0;
    int gap;
    int nhb;
    int nvb;

    logic [31:0] s_fc, s_lt, s_lv, s_pt, s_pv;
    logic        s_st, s_done, s_done_pre, s_done0;

    int exp_lt [10] = '{0, 262, 262, 262, 262, 263, 262, 262, 262, 262};
    bit exp_st [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    jtframe_frame_stats #(
        .CW(CW), .LW(LW), .PW(PW), .MAXFRAME(5), .STABLE_FRAMES(3)
    ) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
        .hs(hs), .vs(vs), .hb(hb), .vb(vb),
        .frame_cnt(frame_cnt), .frame_stb(frame_stb),
        .pxl_total(pxl_total), .pxl_vis(pxl_vis),
        .lines_total(lines_total), .lines_vis(lines_vis),
        .stable(stable), .frames_done(frames_done)
    );

    jtframe_frame_stats #(
        .CW(CW), .LW(LW), .PW(PW), .MAXFRAME(0), .STABLE_FRAMES(3)
    ) dut_nomax (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
        .hs(hs), .vs(vs), .hb(hb), .vb(vb),
        .frame_cnt(n_frame_cnt), .frame_stb(n_frame_stb),
        .pxl_total(n_pxl_total), .pxl_vis(n_pxl_vis),
        .lines_total(n_lines_total), .lines_vis(n_lines_vis),
        .stable(n_stable), .frames_done(n_frames_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One sample: 'gap' idle clocks, then one clk with pxl_cen high; returns one clk after the sampling edge.
    task automatic smp(input logic h, input logic v, input logic hbk, input logic vbk);
        pxl_cen = 1'b0;
        repeat (gap) @(negedge clk);
        hs = h; vs = v; hb = hbk; vb = vbk;
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
    endtask

    task automatic do_reset;
        hs = 1'b0; vs = 1'b0; hb = 1'b0; vb = 1'b0; pxl_cen = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_frame(input int nlines, input int npix, input int vsoff);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < npix; p++) begin
                logic v;
                v = (l == 0 && p >= vsoff) || (l == 1) || (l == 2);
                if (l == 0 && p == vsoff) s_done_pre = frames_done;
                smp(p < 2, v, p < nhb, l < nvb);
                if (l == 0 && p == vsoff) begin
                    s_fc = frame_cnt;   s_lt = 32'(lines_total); s_lv = 32'(lines_vis);
                    s_pt = 32'(pxl_total); s_pv = 32'(pxl_vis);
                    s_st = stable;      s_done = frames_done;    s_done0 = n_frames_done;
                    check("stb_pulse", 32'(frame_stb), 32'd1);
                    @(negedge clk);
                    check("stb_clear", 32'(frame_stb), 32'd0);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; hs = 1'b0; vs = 1'b0; hb = 1'b0; vb = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_frame_cnt",   frame_cnt, 32'd0);
        check("rst_frame_stb",   32'(frame_stb), 32'd0);
        check("rst_pxl_total",   32'(pxl_total), 32'd0);
        check("rst_pxl_vis",     32'(pxl_vis), 32'd0);
        check("rst_lines_total", 32'(lines_total), 32'd0);
        check("rst_lines_vis",   32'(lines_vis), 32'd0);
        check("rst_stable",      32'(stable), 32'd0);
        check("rst_done",        32'(frames_done), 32'd0);

        // Wide lines, pxl_cen every 4th clk, short 3-line frames
        gap = 3; nhb = 64; nvb = 1;
        run_frame(3, 384, 4);
        check("p1_r1_frame_cnt",   s_fc, 32'd1);
        check("p1_r1_lines_total", s_lt, 32'd0);
        run_frame(3, 384, 4);
        check("p1_r2_frame_cnt",   s_fc, 32'd2);
        check("p1_r2_pxl_total",   s_pt, 32'd384);
        check("p1_r2_pxl_vis",     s_pv, 32'd320);
        check("p1_r2_lines_total", s_lt, 32'd3);
        check("p1_r2_lines_vis",   s_lv, 32'd2);

        // 262-line frames at full sample rate; frame 5 is 263 lines
        do_reset();
        gap = 0; nhb = 2; nvb = 38;
        for (int k = 1; k <= 10; k++) begin
            run_frame((k == 5) ? 263 : ((k == 10) ? 3 : 262), 8, 4);
            check($sformatf("p2_r%0d_frame_cnt", k),   s_fc, 32'(k));
            check($sformatf("p2_r%0d_lines_total", k), s_lt, 32'(exp_lt[k-1]));
            check($sformatf("p2_r%0d_stable", k),      32'(s_st), 32'(exp_st[k-1]));
            check($sformatf("p2_r%0d_done", k),        32'(s_done), 32'(k >= 5));
            check($sformatf("p2_r%0d_done_nomax", k),  32'(s_done0), 32'd0);
            if (k == 2) begin
                check("p2_r2_lines_vis", s_lv, 32'd224);
                check("p2_r2_pxl_total", s_pt, 32'd8);
                check("p2_r2_pxl_vis",   s_pv, 32'd6);
            end
            if (k == 5) check("p2_r5_done_pre", 32'(s_done_pre), 32'd0);
        end

        // hs and vs rising in the same sample
        do_reset();
        run_frame(262, 8, 4);
        run_frame(262, 8, 0);
        check("p3_r2_lines_total", s_lt, 32'd261);
        check("p3_r2_lines_vis",   s_lv, 32'd224);
        run_frame(3, 8, 0);
        check("p3_r3_lines_total", s_lt, 32'd262);
        check("p3_r3_lines_vis",   s_lv, 32'd224);

        // Reset in the middle of a line
        for (int p = 0; p < 4; p++) smp(p < 2, 1'b0, p < 2, 1'b0);
        do_reset();
        check("p4_frame_cnt",   frame_cnt, 32'd0);
        check("p4_frame_stb",   32'(frame_stb), 32'd0);
        check("p4_pxl_total",   32'(pxl_total), 32'd0);
        check("p4_pxl_vis",     32'(pxl_vis), 32'd0);
        check("p4_lines_total", 32'(lines_total), 32'd0);
        check("p4_lines_vis",   32'(lines_vis), 32'd0);
        check("p4_stable",      32'(stable), 32'd0);
        check("p4_done",        32'(frames_done), 32'd0);
        run_frame(3, 8, 4);
        check("p4_r1_frame_cnt",   s_fc, 32'd1);
        check("p4_r1_pxl_total",   s_pt, 32'd0);
        check("p4_r1_lines_total", s_lt, 32'd0);
        check("p4_pxl_total_after", 32'(pxl_total), 32'd8);

        // 1100-sample line saturates the 10-bit pixel counters
        do_reset();
        smp(1'b1, 1'b0, 1'b0, 1'b0);
        for (int p = 1; p < 1100; p++) smp(1'b0, 1'b0, 1'b0, 1'b0);
        smp(1'b1, 1'b0, 1'b0, 1'b0);
        check("p5_pxl_total_sat", 32'(pxl_total), 32'd1023);
        check("p5_pxl_vis_sat",   32'(pxl_vis), 32'd1023);
        check("p5_frame_cnt",     frame_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
